// File: rtl/level_pkg.sv
// Shared definitions for the level tile RAM and its collision probe.
// Holds the level geometry, the tile/address types, the probe FSM state
// encoding and a helper deciding whether a tile ID is solid.
package level_pkg;

  localparam int LEVEL_W_TILES = 201;
  localparam int LEVEL_H_TILES = 30;
  localparam int TILE_SHIFT    = 4;
  localparam int LEVEL_WORDS   = LEVEL_W_TILES * LEVEL_H_TILES;
  localparam int SOLID_MIN     = 4;

  typedef logic [4:0]  tile_id_t;
  typedef logic [18:0] level_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } probe_state_t;

  // Tiles at or above SOLID_MIN block movement.
  function automatic logic isSolidTile(input tile_id_t tile);
    return tile >= tile_id_t'(SOLID_MIN);
  endfunction

endpackage

// File: rtl/level_tile_addr.sv
// Combinational pixel-to-tile address translation.
// Ports:
//   pixX_i  in  13  level pixel x (wide enough for box right edge)
//   pixY_i  in  10  level pixel y (wide enough for box bottom edge)
//   addr_o  out 19  row*LEVEL_W_TILES + col, or 0 when out of bounds
//   oob_o   out 1   tile lies outside the level
module level_tile_addr
  import level_pkg::*;
(
  input  logic [12:0] pixX_i,
  input  logic [9:0]  pixY_i,
  output level_addr_t addr_o,
  output logic        oob_o
);

  logic [12:0] col;
  logic [9:0]  row;

  // Tile coordinates from pixel coordinates; out-of-bounds corners are
  // forced to address 0 so the RAM never sees an address beyond the level.
  always_comb begin
    col    = pixX_i >> TILE_SHIFT;
    row    = pixY_i >> TILE_SHIFT;
    oob_o  = (col >= 13'(LEVEL_W_TILES)) || (row >= 10'(LEVEL_H_TILES));
    addr_o = '0;
    if (!oob_o) begin
      addr_o = level_addr_t'(row) * level_addr_t'(LEVEL_W_TILES) + level_addr_t'(col);
    end
  end

endmodule

// File: rtl/level_collision_probe.sv
// Level collision probe: reads the four corner tiles of a sprite bounding
// box from the level tile RAM and reports tile IDs, solid and
// out-of-bounds flags per corner (0=TL, 1=TR, 2=BL, 3=BR).
// Ports:
//   Clk, Reset_n            clock and synchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_x/req_y/req_w/req_h box left/top in pixels, width/height (0 -> 1)
//   rd_addr/rd_data         level RAM read port (1-cycle registered read)
//   resp_valid              one-cycle response strobe
//   resp_tile/solid/oob     per-corner results, held until next response
module level_collision_probe
  import level_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [11:0]        req_x,
  input  logic [8:0]         req_y,
  input  logic [5:0]         req_w,
  input  logic [5:0]         req_h,
  output level_addr_t        rd_addr,
  input  tile_id_t           rd_data,
  output logic               resp_valid,
  output tile_id_t [3:0]     resp_tile,
  output logic [3:0]         resp_solid,
  output logic [3:0]         resp_oob
);

  probe_state_t   state_q, state_d;
  logic [1:0]     cornerIdx_q, cornerIdx_d;
  logic           drainCnt_q, drainCnt_d;
  logic           respLoad;
  logic           accept;
  logic           issueNow;

  logic [12:0]    xLeft_q, xRight_q;
  logic [9:0]     yTop_q, yBot_q;
  logic [5:0]     wEff, hEff;

  logic [12:0]    probeX;
  logic [9:0]     probeY;
  level_addr_t    cornerAddr;
  logic           cornerOob;

  level_addr_t    rdAddr_q;

  logic           tag1Valid_q, tag2Valid_q;
  logic [1:0]     tag1Idx_q, tag2Idx_q;
  logic           tag1Oob_q, tag2Oob_q;

  tile_id_t [3:0] bufTile_q;
  logic [3:0]     bufOob_q;
  tile_id_t       capTile;
  tile_id_t [3:0] mergedTile;
  logic [3:0]     mergedOob;
  logic [3:0]     mergedSolid;

  logic           respValid_q;
  tile_id_t [3:0] respTile_q;
  logic [3:0]     respSolid_q;
  logic [3:0]     respOob_q;

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_ready && req_valid;
  assign issueNow   = (state_q == ISSUE);
  assign rd_addr    = rdAddr_q;
  assign resp_valid = respValid_q;
  assign resp_tile  = respTile_q;
  assign resp_solid = respSolid_q;
  assign resp_oob   = respOob_q;

  assign wEff = (req_w == 6'd0) ? 6'd1 : req_w;
  assign hEff = (req_h == 6'd0) ? 6'd1 : req_h;

  // Corner k picks the right edge when bit 0 is set and the bottom edge
  // when bit 1 is set, giving TL, TR, BL, BR order.
  assign probeX = cornerIdx_q[0] ? xRight_q : xLeft_q;
  assign probeY = cornerIdx_q[1] ? yBot_q   : yTop_q;

  level_tile_addr uAddr (
    .pixX_i (probeX),
    .pixY_i (probeY),
    .addr_o (cornerAddr),
    .oob_o  (cornerOob)
  );

  // Next-state logic: four issue cycles, two drain cycles waiting for the
  // last corner's data, then load the response on the way back to IDLE.
  always_comb begin
    state_d     = state_q;
    cornerIdx_d = cornerIdx_q;
    drainCnt_d  = drainCnt_q;
    respLoad    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d     = ISSUE;
          cornerIdx_d = 2'd0;
        end
      end
      ISSUE: begin
        cornerIdx_d = cornerIdx_q + 2'd1;
        if (cornerIdx_q == 2'd3) begin
          state_d    = DRAIN;
          drainCnt_d = 1'b0;
        end
      end
      DRAIN: begin
        if (drainCnt_q) begin
          state_d  = IDLE;
          respLoad = 1'b1;
        end else begin
          drainCnt_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register for the probe FSM.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      cornerIdx_q <= 2'd0;
      drainCnt_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cornerIdx_q <= cornerIdx_d;
      drainCnt_q  <= drainCnt_d;
    end
  end

  // Latch box edges at accept; right/bottom edges are widened so they
  // never wrap past the level edge.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      xLeft_q  <= '0;
      xRight_q <= '0;
      yTop_q   <= '0;
      yBot_q   <= '0;
    end else if (accept) begin
      xLeft_q  <= {1'b0, req_x};
      xRight_q <= {1'b0, req_x} + 13'(wEff) - 13'd1;
      yTop_q   <= {1'b0, req_y};
      yBot_q   <= {1'b0, req_y} + 10'(hEff) - 10'd1;
    end
  end

  // Read issue plus a two-stage tag pipe that follows each read through
  // the address register and the RAM's output register.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rdAddr_q    <= '0;
      tag1Valid_q <= 1'b0;
      tag1Idx_q   <= 2'd0;
      tag1Oob_q   <= 1'b0;
      tag2Valid_q <= 1'b0;
      tag2Idx_q   <= 2'd0;
      tag2Oob_q   <= 1'b0;
    end else begin
      if (issueNow) begin
        rdAddr_q <= cornerAddr;
      end
      tag1Valid_q <= issueNow;
      tag1Idx_q   <= cornerIdx_q;
      tag1Oob_q   <= cornerOob;
      tag2Valid_q <= tag1Valid_q;
      tag2Idx_q   <= tag1Idx_q;
      tag2Oob_q   <= tag1Oob_q;
    end
  end

  // The last corner arrives on the same edge the response is loaded, so
  // the response sees the capture buffer with the current read merged in.
  always_comb begin
    capTile    = tag2Oob_q ? tile_id_t'(0) : rd_data;
    mergedTile = bufTile_q;
    mergedOob  = bufOob_q;
    if (tag2Valid_q) begin
      mergedTile[tag2Idx_q] = capTile;
      mergedOob[tag2Idx_q]  = tag2Oob_q;
    end
    for (int i = 0; i < 4; i++) begin
      mergedSolid[i] = mergedOob[i] | isSolidTile(mergedTile[i]);
    end
  end

  // Capture buffer and the externally visible response registers.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      bufTile_q   <= '0;
      bufOob_q    <= '0;
      respValid_q <= 1'b0;
      respTile_q  <= '0;
      respSolid_q <= '0;
      respOob_q   <= '0;
    end else begin
      bufTile_q   <= mergedTile;
      bufOob_q    <= mergedOob;
      respValid_q <= respLoad;
      if (respLoad) begin
        respTile_q  <= mergedTile;
        respSolid_q <= mergedSolid;
        respOob_q   <= mergedOob;
      end
    end
  end

endmodule

// File: tb/tb_level_collision_probe.sv
// Scoreboard bench for level_collision_probe with a behavioural RAM model.
module tb_level_collision_probe;

  logic              Clk;
  logic              Reset_n;
  logic              req_valid;
  logic              req_ready;
  logic [11:0]       req_x;
  logic [8:0]        req_y;
  logic [5:0]        req_w;
  logic [5:0]        req_h;
  logic [18:0]       rd_addr;
  logic [4:0]        rdData;
  logic              resp_valid;
  logic [3:0][4:0]   resp_tile;
  logic [3:0]        resp_solid;
  logic [3:0]        resp_oob;

  typedef struct {
    int              due;
    logic [3:0][4:0] tile;
    logic [3:0]      solid;
    logic [3:0]      oob;
  } respExp_t;

  typedef struct {
    int          cyc;
    logic [18:0] addr;
  } addrExp_t;

  respExp_t respQ[$];
  addrExp_t addrQ[$];

  logic [4:0] ram [0:6029];
  int cyc = 0;
  int nextOk = 0;
  int total = 0;
  int bad = 0;
  int pulses = 0;
  bit monitorOn = 0;

  level_collision_probe dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_w      (req_w),
    .req_h      (req_h),
    .rd_addr    (rd_addr),
    .rd_data    (rdData),
    .resp_valid (resp_valid),
    .resp_tile  (resp_tile),
    .resp_solid (resp_solid),
    .resp_oob   (resp_oob)
  );

  // Free-running clock and edge counter.
  initial Clk = 0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Level RAM: one-cycle registered read.
  always @(posedge Clk) begin
    if (rd_addr < 19'd6030) rdData <= ram[int'(rd_addr)];
    else rdData <= 5'd0;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one request and, on the edge the model says it is accepted,
  // push the expected read addresses and response from tile arithmetic.
  task automatic applyStimulus(input int x, input int y, input int w, input int h);
    req_x = 12'(x);
    req_y = 9'(y);
    req_w = 6'(w);
    req_h = 6'(h);
    req_valid = 1'b1;
    for (int guard = 0; guard < 16; guard++) begin
      if (cyc + 1 >= nextOk) begin
        int acc, we, he;
        respExp_t e;
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        acc = cyc + 1;
        we = (w == 0) ? 1 : w;
        he = (h == 0) ? 1 : h;
        e.due = acc + 6;
        for (int k = 0; k < 4; k++) begin
          int px, py, col, row, addr, tile;
          bit oob;
          px = (k % 2 == 1) ? x + we - 1 : x;
          py = (k >= 2) ? y + he - 1 : y;
          col = px / 16;
          row = py / 16;
          oob = (col >= 201) || (row >= 30);
          addr = oob ? 0 : row * 201 + col;
          tile = oob ? 0 : int'(ram[addr]);
          e.tile[k] = 5'(tile);
          e.oob[k] = oob;
          e.solid[k] = oob || (tile >= 4);
          addrQ.push_back('{acc + 1 + k, 19'(addr)});
        end
        respQ.push_back(e);
        nextOk = acc + 7;
        @(posedge Clk);
        @(negedge Clk);
        return;
      end
      checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
      @(negedge Clk);
    end
    checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, "_resp_tile"}, 32'(resp_tile), 32'd0);
    checkOutput({tag, "_resp_solid"}, 32'(resp_solid), 32'd0);
    checkOutput({tag, "_resp_oob"}, 32'(resp_oob), 32'd0);
  endtask

  // Monitor: compares read addresses at their expected edges and each
  // response against the scoreboard at its due cycle.
  always @(negedge Clk) begin
    if (monitorOn) begin
      while (addrQ.size() > 0 && addrQ[0].cyc <= cyc) begin
        addrExp_t a;
        a = addrQ.pop_front();
        checkOutput("rd_addr", 32'(rd_addr), 32'(a.addr));
      end
      if (respQ.size() > 0 && respQ[0].due <= cyc) begin
        respExp_t e;
        e = respQ.pop_front();
        checkOutput("resp_valid_at_due", 32'(resp_valid), 32'd1);
        if (resp_valid === 1'b1) begin
          pulses++;
          checkOutput("resp_tile", 32'(resp_tile), 32'(e.tile));
          checkOutput("resp_solid", 32'(resp_solid), 32'(e.solid));
          checkOutput("resp_oob", 32'(resp_oob), 32'(e.oob));
        end
      end else if (resp_valid === 1'b1) begin
        pulses++;
        checkOutput("resp_unexpected", 32'(resp_valid), 32'd0);
      end
    end
  end

  initial begin
    int pulseBase;
    Reset_n = 0;
    req_valid = 0;
    req_x = '0;
    req_y = '0;
    req_w = '0;
    req_h = '0;
    for (int i = 0; i < 6030; i++) ram[i] = 5'($urandom_range(0, 31));
    ram[405] = 5'd5;
    ram[200] = 5'd2;
    ram[202] = 5'd9;

    // Reset state.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1;
    nextOk = cyc + 1;
    monitorOn = 1;
    $display("[TB] reset state");
    checkResetState("reset");

    // Directed: solid block, right-edge oob, zero-size box.
    applyStimulus(48, 32, 16, 16);
    req_valid = 0;
    applyStimulus(3210, 0, 16, 16);
    req_valid = 0;
    applyStimulus(17, 20, 0, 0);
    req_valid = 0;
    repeat (8) @(negedge Clk);

    // req_valid held high across three back-to-back requests.
    pulseBase = pulses;
    applyStimulus(100, 40, 20, 30);
    applyStimulus(3000, 470, 63, 63);
    applyStimulus(0, 0, 1, 1);
    req_valid = 0;
    repeat (8) @(negedge Clk);
    checkOutput("held_valid_pulses", 32'(pulses - pulseBase), 32'd3);

    // Reset mid-request: the aborted request must never respond.
    $display("[TB] mid-request reset");
    applyStimulus(160, 64, 8, 8);
    req_valid = 0;
    @(negedge Clk);
    @(negedge Clk);
    Reset_n = 0;
    @(posedge Clk);
    respQ.delete();
    addrQ.delete();
    @(negedge Clk);
    Reset_n = 1;
    nextOk = cyc + 1;
    checkResetState("midreset");
    repeat (10) @(negedge Clk);

    // Randomized requests with random idle gaps.
    $display("[TB] random requests");
    for (int n = 0; n < 30; n++) begin
      int rx, ry;
      rx = (n % 2 == 0) ? int'($urandom_range(0, 3300)) : int'($urandom_range(0, 4095));
      ry = (n % 3 == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 470));
      applyStimulus(rx, ry, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      if ($urandom_range(0, 1) == 1) begin
        req_valid = 0;
        repeat ($urandom_range(0, 9)) @(negedge Clk);
      end
    end
    req_valid = 0;

    for (int t = 0; t < 20 && respQ.size() > 0; t++) @(negedge Clk);
    @(negedge Clk);
    checkOutput("resp_queue_drained", 32'(respQ.size()), 32'd0);
    checkOutput("addr_queue_drained", 32'(addrQ.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
